// File: rtl/uart_tx_fifo_pkg.sv
// Types and helpers shared by the UART TX character FIFO and its interface.
package uart_tx_fifo_pkg;
`include "uart_defs.vh"

  localparam int UART_CHAR_W         = `UART_CHAR_W;
  localparam int FIFO_ADDR_W_DEFAULT = `UART_FIFO_ADDR_W_DEFAULT;

  typedef logic [UART_CHAR_W-1:0] uart_char_t;

  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
  } fifo_op_t;

  // A pop frees a slot in the same cycle, so a write to a full FIFO survives if a pop accompanies it.
  function automatic fifo_op_t fifo_decide(input logic wr, input logic tx,
                                           input logic is_empty, input logic is_full);
    fifo_op_t op;
    op.pop  = tx & ~is_empty;
    op.push = wr & (~is_full | op.pop);
    op.drop = wr & ~op.push;
    return op;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host/transmitter-facing signal bundle of uart_tx_fifo; UART_TX_FIFO_FLUSH_EN adds flush.
interface uart_tx_fifo_if import uart_tx_fifo_pkg::*; #(
  parameter int ADDR_W = FIFO_ADDR_W_DEFAULT
);
  uart_char_t        wr_data;
  logic              wr_en;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  uart_char_t        char;
  logic              load;
  logic              transmitted;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic              flush;

  modport master (output wr_data, wr_en, transmitted, flush,
                  input  full, empty, level, overflow, char, load);
  modport slave  (input  wr_data, wr_en, transmitted, flush,
                  output full, empty, level, overflow, char, load);
`else
  modport master (output wr_data, wr_en, transmitted,
                  input  full, empty, level, overflow, char, load);
  modport slave  (input  wr_data, wr_en, transmitted,
                  output full, empty, level, overflow, char, load);
`endif
endinterface

// File: rtl/uart_defs.vh
// Shared UART constants used by the TX and RX character FIFOs.
`ifndef UART_DEFS_VH
`define UART_DEFS_VH
`define UART_CHAR_W 8
`define UART_FIFO_ADDR_W_DEFAULT 4
`endif

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register file: synchronous write port, asynchronous read port, no reset.
module uart_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Character FIFO feeding uart_transmitter: head byte on char/load, popped per transmitted pulse.
// Optional UART_TX_FIFO_FLUSH_EN adds a flush input that empties the queue but keeps overflow.
module uart_tx_fifo import uart_tx_fifo_pkg::*; #(
  parameter int ADDR_W = FIFO_ADDR_W_DEFAULT
) (
  input  logic           clock,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow_q;
  uart_char_t        rd_char;
  fifo_op_t          op;

  assign op = fifo_decide(bus.wr_en, bus.transmitted, count == '0, count == DEPTH_CNT);

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end
`ifdef UART_TX_FIFO_FLUSH_EN
    else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end
`endif
    else begin
      if (op.push) wr_ptr <= wr_ptr + 1'b1;
      if (op.pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({op.push, op.pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (op.drop) overflow_q <= 1'b1;
    end
  end

  // A write landing during rst/flush only touches storage; the cleared pointers make it unreachable.
  uart_fifo_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (UART_CHAR_W)
  ) u_mem (
    .clock (clock),
    .we    (op.push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_char)
  );

  assign bus.full     = (count == DEPTH_CNT);
  assign bus.empty    = (count == '0);
  assign bus.level    = count;
  assign bus.overflow = overflow_q;
  assign bus.load     = (count != '0);
  assign bus.char     = (count != '0) ? rd_char : '0;
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Character buffer that sits directly upstream of uart_transmitter. It accepts bytes from the host/bus side and presents the head-of-queue byte on char with load asserted while data is pending. It pops one entry per transmitted pulse, so back-to-back characters go out without host intervention. Single clock domain, shared with the transmitter.

Parameters:
ADDR_W, 4, log2 of FIFO depth; DEPTH = 2**ADDR_W (default 16 entries)

Ports:
clock  input  1  system clock; same clock as uart_transmitter
rst  input  1  reset, synchronous, active-high
wr_data  input  8  byte to enqueue
wr_en  input  1  enqueue strobe, one byte per cycle while high
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was dropped because the FIFO was full
char  output  8  head-of-queue byte, to uart_transmitter.char
load  output  1  data pending, to uart_transmitter.load; equals !empty
transmitted  input  1  one-cycle pulse from uart_transmitter when the current char is finished

Behaviour:
- Reset (rst=1 at posedge): rd_ptr=0, wr_ptr=0, count=0, overflow=0. Outputs become empty=1, full=0, level=0, load=0, char=8'h00. Memory contents are not reset.
- Storage: DEPTH x 8 register array. rd_ptr and wr_ptr are ADDR_W bits and wrap modulo DEPTH. count is ADDR_W+1 bits.
- Flags: full, empty and level are decoded from registered count and are valid the cycle after the event that changes count.
- char = mem[rd_ptr] (combinational read of the registers) when count!=0, else 8'h00. char is stable for as long as rd_ptr is unchanged.
- load = (count!=0). There is no extra latency: the first write into an empty FIFO makes load=1 and char=data on the following cycle.
- Push: wr_en=1 and (count<DEPTH, or a pop occurs in the same cycle) -> mem[wr_ptr]<=wr_data, wr_ptr<=wr_ptr+1.
- Pop: transmitted=1 and count!=0 -> rd_ptr<=rd_ptr+1. The next byte appears on char the following cycle.
- Count update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
- Full + write + pop in the same cycle: the write is accepted and overflow is not set.
- Full + write, no pop: the byte is dropped, pointers and count are unchanged, overflow<=1. overflow clears only on rst.
- transmitted while empty: ignored. Pointers and count do not change; no underflow wrap.
- Empty + write + transmitted in the same cycle: the pop is ignored (count was 0) and the push is accepted.
- rst asserted mid-operation (including mid-character) discards all queued data. The transmitter is reset by the same rst, so no partial pop can occur.
- Ordering: strict FIFO, no reordering. The byte sequence at txd matches the accepted wr_data sequence.

Optional Feature:
UART_TX_FIFO_FLUSH_EN
- Defined: adds input port flush (1 bit). flush=1 at posedge clears rd_ptr, wr_ptr and count to 0 (same as rst) but leaves overflow untouched. flush has priority over a simultaneous push or pop. The character already being shifted by the transmitter still completes; its transmitted pulse then sees an empty FIFO and is ignored.
- Not defined: no flush port. The port list is exactly as above.

Decomposition:
- Shared header uart_defs.vh (included with `include): UART_CHAR_W=8 and a default FIFO depth constant. This header is shared with the planned uart_rx_fifo.
- One natural sub-module: uart_fifo_mem, the DEPTH x 8 register file with a synchronous write port and an asynchronous read port. Pointer, count and flag logic stay in uart_tx_fifo.

Test Plan:
- Reset, then write 0x55, 0xAA, 0x0F on consecutive cycles -> load=1 one cycle after the first write, level=3, char=0x55. After each transmitted pulse char steps 0xAA then 0x0F, then load=0 and empty=1.
- With ADDR_W=4, write 16 bytes 0x00..0x0F with no pops -> full=1, level=16. A 17th write of 0xFF -> overflow=1 and level stays 16. Drain via 16 pulses -> chars observed are 0x00..0x0F in order, 0xFF never appears.
- FIFO full, wr_en=1 with wr_data=0x77 in the same cycle as transmitted -> level stays 16, overflow stays 0, and 0x77 is the 16th char popped afterwards.
- Empty FIFO, transmitted pulse alone -> level=0, load=0, char=0x00, pointers unchanged. A subsequent write of 0x3C is then the char presented.
- End-to-end with uart_transmitter and uart_receiver (btu=319, 8N1, loopback txd->rxd): enqueue 0x00..0xFF paced on !full -> the receiver reports 256 chars equal to 0x00..0xFF in order, and overflow=0.
- Load 5 bytes, assert rst for one cycle mid-character -> on the next cycle level=0, load=0, overflow=0. With UART_TX_FIFO_FLUSH_EN, flush with overflow=1 leaves overflow=1 and level=0.
